// File: rtl/fir_pkg.sv
// Shared definitions for the sequential multi-channel FIR: FSM state encoding
// and the accumulator / requantisation width helpers.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fir_state_t;

    // Accumulator width: full product plus growth for summing num_elem terms.
    function automatic int fir_acc_bits(input int bits_per_elem, input int num_elem);
        return 2 * bits_per_elem + $clog2(num_elem);
    endfunction

    // Number of LSBs dropped when squeezing the accumulator into the output width.
    function automatic int fir_shift(input int acc_bits, input int sum_truncation);
        return acc_bits - sum_truncation;
    endfunction

endpackage

// File: rtl/fir_requant.sv
// Combinational requantiser: drops the accumulator LSBs either by floor
// truncation or by round-half-up with saturation to the output range.
module fir_requant #(
    parameter int ACC_BITS       = 19,
    parameter int SUM_TRUNCATION = 8,
    parameter int ROUND          = 1
) (
    input  logic signed [ACC_BITS-1:0]       i_acc,
    output logic signed [SUM_TRUNCATION-1:0] o_q
);

    localparam int SHIFT = ACC_BITS - SUM_TRUNCATION;
    localparam int QW    = SUM_TRUNCATION + 1;

    generate
        if (ROUND == 0) begin : g_floor
            // Arithmetic shift keeps only the top SUM_TRUNCATION bits (floor).
            always_comb begin
                o_q = SUM_TRUNCATION'(i_acc >>> SHIFT);
            end
        end else begin : g_round
            // One extra bit absorbs the rounding carry so the add never overflows.
            localparam logic signed [ACC_BITS:0] HALF  = {{ACC_BITS{1'b0}}, 1'b1} << (SHIFT - 1);
            localparam logic signed [QW-1:0]     Q_MAX = {2'b00, {(SUM_TRUNCATION-1){1'b1}}};
            localparam logic signed [QW-1:0]     Q_MIN = {2'b11, {(SUM_TRUNCATION-1){1'b0}}};

            logic signed [ACC_BITS:0] w_sum;
            logic signed [QW-1:0]     w_shr;

            // Add half an output LSB, shift, then clamp into the output range.
            always_comb begin
                w_sum = {i_acc[ACC_BITS-1], i_acc} + HALF;
                w_shr = QW'(w_sum >>> SHIFT);
                if (w_shr > Q_MAX) begin
                    o_q = Q_MAX[SUM_TRUNCATION-1:0];
                end else if (w_shr < Q_MIN) begin
                    o_q = Q_MIN[SUM_TRUNCATION-1:0];
                end else begin
                    o_q = w_shr[SUM_TRUNCATION-1:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fir_seq_multi.sv
// Sequential multi-channel FIR: one shared signed multiplier walks every
// (channel, element) pair of a snapshotted tap vector, requantises each
// channel's sum and publishes all channels together with a one-cycle o_valid.
module fir_seq_multi
    import fir_pkg::*;
#(
    parameter int BITS_PER_ELEM  = 8,
    parameter int NUM_ELEM       = 7,
    parameter int NUM_CHAN       = 4,
    parameter int SUM_TRUNCATION = 8,
    parameter int ROUND          = 1,
    parameter logic [NUM_CHAN*NUM_ELEM*BITS_PER_ELEM-1:0] FILTER_VAL = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_start_calc,
    input  logic [NUM_ELEM*BITS_PER_ELEM-1:0]        taps,
    input  logic                                     i_coef_we,
    input  logic [$clog2(NUM_CHAN*NUM_ELEM)-1:0]     i_coef_addr,
    input  logic [BITS_PER_ELEM-1:0]                 i_coef_data,
    output logic                                     o_busy,
    output logic                                     o_valid,
    output logic [NUM_CHAN*SUM_TRUNCATION-1:0]       o_wavelet
);

    localparam int B        = BITS_PER_ELEM;
    localparam int ST       = SUM_TRUNCATION;
    localparam int NUM_COEF = NUM_CHAN * NUM_ELEM;
    localparam int ADDR_W   = $clog2(NUM_COEF);
    localparam int ACC_BITS = fir_acc_bits(BITS_PER_ELEM, NUM_ELEM);
    localparam int SHIFT    = fir_shift(ACC_BITS, SUM_TRUNCATION);
    localparam int C_W      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int E_W      = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;

    generate
        if (SHIFT < 1) begin : g_shift_check
            $error("fir_seq_multi: SUM_TRUNCATION must be narrower than the accumulator");
        end
    endgenerate

    fir_state_t                 r_state;
    fir_state_t                 w_state_nxt;
    logic [C_W-1:0]             r_c;
    logic [E_W-1:0]             r_e;
    logic signed [ACC_BITS-1:0] r_acc;
    logic signed [ACC_BITS-1:0] w_acc_sum;
    logic [NUM_ELEM*B-1:0]      r_snap;
    logic signed [B-1:0]        r_coef [NUM_COEF];
    logic signed [ST-1:0]       r_stage [NUM_CHAN];
    logic [ADDR_W-1:0]          w_idx;
    logic signed [B-1:0]        w_coef;
    logic signed [B-1:0]        w_tap;
    logic signed [2*B-1:0]      w_prod;
    logic signed [ST-1:0]       w_q;
    logic                       w_last_e;
    logic                       w_last_c;
    logic [NUM_CHAN*ST-1:0]     w_wave_nxt;

    // Current channel's sum (including this cycle's product) requantised.
    fir_requant #(
        .ACC_BITS       (ACC_BITS),
        .SUM_TRUNCATION (SUM_TRUNCATION),
        .ROUND          (ROUND)
    ) u_requant (
        .i_acc (w_acc_sum),
        .o_q   (w_q)
    );

    // Multiply-accumulate datapath and end-of-row / end-of-run detection.
    always_comb begin
        w_idx     = ADDR_W'(int'(r_c) * NUM_ELEM + int'(r_e));
        w_coef    = r_coef[w_idx];
        w_tap     = r_snap[int'(r_e)*B +: B];
        w_prod    = w_coef * w_tap;
        w_acc_sum = r_acc + ACC_BITS'(w_prod);
        w_last_e  = (r_e == E_W'(NUM_ELEM - 1));
        w_last_c  = (r_c == C_W'(NUM_CHAN - 1));
        for (int c = 0; c < NUM_CHAN; c++) begin
            w_wave_nxt[c*ST +: ST] = r_stage[c];
        end
        // The last channel's result is not staged; it goes straight out.
        w_wave_nxt[(NUM_CHAN-1)*ST +: ST] = w_q;
    end

    // Next-state decode: IDLE -> CALC on start, CALC -> DONE after the final product.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start_calc) begin
                    w_state_nxt = ST_CALC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (w_last_e && w_last_c) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_busy  <= (w_state_nxt != ST_IDLE);
            o_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Coefficient store, tap snapshot, accumulator, counters and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= {ACC_BITS{1'b0}};
            r_c       <= {C_W{1'b0}};
            r_e       <= {E_W{1'b0}};
            r_snap    <= {(NUM_ELEM*B){1'b0}};
            o_wavelet <= {(NUM_CHAN*ST){1'b0}};
            for (int i = 0; i < NUM_CHAN; i++) begin
                r_stage[i] <= {ST{1'b0}};
            end
            for (int i = 0; i < NUM_COEF; i++) begin
                r_coef[i] <= FILTER_VAL[i*B +: B];
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Writes land before the snapshot is used, so a same-cycle
                    // write and start computes with the new coefficient.
                    if (i_coef_we && (int'(i_coef_addr) < NUM_COEF)) begin
                        r_coef[i_coef_addr] <= i_coef_data;
                    end
                    if (i_start_calc) begin
                        r_snap <= taps;
                        r_acc  <= {ACC_BITS{1'b0}};
                        r_c    <= {C_W{1'b0}};
                        r_e    <= {E_W{1'b0}};
                    end
                end
                ST_CALC: begin
                    if (w_last_e) begin
                        r_stage[r_c] <= w_q;
                        r_acc        <= {ACC_BITS{1'b0}};
                        r_e          <= {E_W{1'b0}};
                        if (w_last_c) begin
                            r_c       <= {C_W{1'b0}};
                            o_wavelet <= w_wave_nxt;
                        end else begin
                            r_c <= r_c + C_W'(1'b1);
                        end
                    end else begin
                        r_acc <= w_acc_sum;
                        r_e   <= r_e + E_W'(1'b1);
                    end
                end
                ST_DONE: begin
                    r_acc <= {ACC_BITS{1'b0}};
                end
                default: begin
                    r_acc <= {ACC_BITS{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_seq_multi.sv
// Self-checking bench for fir_seq_multi: a floor and a rounding instance share
// stimulus; expected wavelets come from a behavioural model into scoreboards.
module tb_fir_seq_multi;

    localparam int B     = 8;
    localparam int NE    = 7;
    localparam int NC    = 2;
    localparam int ST    = 8;
    localparam int NCOEF = NC * NE;

    function automatic logic [NCOEF*B-1:0] mk_fv();
        logic [NCOEF*B-1:0] v;
        for (int i = 0; i < NCOEF; i++) begin
            v[i*B +: B] = 8'(i * 9 - 60);
        end
        return v;
    endfunction

    localparam logic [NCOEF*B-1:0] FV = mk_fv();

    logic              clk;
    logic              rst;
    logic              start;
    logic [NE*B-1:0]   taps;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic [B-1:0]      coef_data;
    logic              busy0, valid0, busy1, valid1;
    logic [NC*ST-1:0]  wave0, wave1;

    int                errors = 0;
    int                checks = 0;
    int                m_coef [NCOEF];
    logic [NC*ST-1:0]  exp0_q [$];
    logic [NC*ST-1:0]  exp1_q [$];

    fir_seq_multi #(
        .BITS_PER_ELEM(B), .NUM_ELEM(NE), .NUM_CHAN(NC),
        .SUM_TRUNCATION(ST), .ROUND(0), .FILTER_VAL(FV)
    ) u_dut_r0 (
        .clk(clk), .rst(rst), .i_start_calc(start), .taps(taps),
        .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
        .o_busy(busy0), .o_valid(valid0), .o_wavelet(wave0)
    );

    fir_seq_multi #(
        .BITS_PER_ELEM(B), .NUM_ELEM(NE), .NUM_CHAN(NC),
        .SUM_TRUNCATION(ST), .ROUND(1), .FILTER_VAL(FV)
    ) u_dut_r1 (
        .clk(clk), .rst(rst), .i_start_calc(start), .taps(taps),
        .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
        .o_busy(busy1), .o_valid(valid1), .o_wavelet(wave1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void load_fv_model();
        for (int i = 0; i < NCOEF; i++) begin
            m_coef[i] = int'($signed(FV[i*B +: B]));
        end
    endfunction

    // Reference: exact integer dot products, then floor or round-half-up + clamp.
    function automatic logic [NC*ST-1:0] model(input logic [NE*B-1:0] tp, input bit rnd);
        logic [NC*ST-1:0] res;
        int acc, r;
        for (int c = 0; c < NC; c++) begin
            acc = 0;
            for (int e = 0; e < NE; e++) begin
                acc += m_coef[c*NE+e] * int'($signed(tp[e*B +: B]));
            end
            if (rnd) begin
                r = (acc + 1024) >>> 11;
                if (r > 127)  r = 127;
                if (r < -128) r = -128;
            end else begin
                r = acc >>> 11;
            end
            res[c*ST +: ST] = 8'(r);
        end
        return res;
    endfunction

    task automatic write_coef(input int a, input int d);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 4'(a); coef_data = 8'(d);
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        m_coef[a] = d;
    endtask

    task automatic write_all(input int lo, input int hi, input int d);
        for (int a = lo; a <= hi; a++) write_coef(a, d);
    endtask

    // Start one computation; optionally write a coefficient on the start cycle
    // and/or disturb taps, start and write during CALC. Checks busy, latency,
    // the scoreboard result, the DONE->IDLE return and that the output holds.
    task automatic run_calc(input logic [NE*B-1:0] tp, input bit disturb,
                            input bit wr_now, input int wa, input int wd);
        int n;
        bit seen;
        logic [NC*ST-1:0] e0, e1;
        @(negedge clk);
        taps = tp; start = 1'b1;
        if (wr_now) begin
            coef_we = 1'b1; coef_addr = 4'(wa); coef_data = 8'(wd);
            m_coef[wa] = wd;
        end
        exp0_q.push_back(model(tp, 1'b0));
        exp1_q.push_back(model(tp, 1'b1));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1)
            $display("FAIL busy_after_start: got %b/%b expected 1/1", busy0, busy1);
        if (busy0 !== 1'b1 || busy1 !== 1'b1) errors++;
        seen = 1'b0; n = 0;
        while (!seen && n < 40) begin
            if (disturb && n == 3) begin
                taps = ~tp; start = 1'b1;
                coef_we = 1'b1; coef_addr = 4'd0; coef_data = 8'h55;
            end else begin
                start = 1'b0; coef_we = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            n++;
            if (valid0 === 1'b1 || valid1 === 1'b1) begin
                seen = 1'b1;
            end else begin
                checks++;
                if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_in_calc: edge+%0d got %b/%b expected 1/1", n, busy0, busy1);
                end
            end
        end
        start = 1'b0; coef_we = 1'b0;
        checks++;
        if (n != NC*NE || valid0 !== 1'b1 || valid1 !== 1'b1) begin
            errors++;
            $display("FAIL latency: valid at edge+%0d (%b/%b) expected edge+%0d (1/1)", n, valid0, valid1, NC*NE);
        end
        e0 = (exp0_q.size() > 0) ? exp0_q.pop_front() : 16'hxxxx;
        e1 = (exp1_q.size() > 0) ? exp1_q.pop_front() : 16'hxxxx;
        checks++;
        if (wave0 !== e0) begin
            errors++;
            $display("FAIL wavelet_floor: got %h expected %h", wave0, e0);
        end
        checks++;
        if (wave1 !== e1) begin
            errors++;
            $display("FAIL wavelet_round: got %h expected %h", wave1, e1);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid0 !== 1'b0 || valid1 !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL return_idle: valid %b/%b busy %b/%b expected all 0", valid0, valid1, busy0, busy1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (wave0 !== e0 || wave1 !== e1) begin
            errors++;
            $display("FAIL wavelet_hold: got %h/%h expected %h/%h", wave0, wave1, e0, e1);
        end
    endtask

    task automatic no_valid_window(input int cycles, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid0 !== 1'b0 || valid1 !== 1'b0) hit = 1'b1;
        end
        checks++;
        if (hit) begin
            errors++;
            $display("FAIL %s: got a valid pulse expected none", tag);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = 4'd0;
        coef_data = 8'd0; taps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        load_fv_model();
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy0, busy1);
        end
        checks++;
        if (valid0 !== 1'b0 || valid1 !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b/%b expected 0/0", valid0, valid1);
        end
        checks++;
        if (wave0 !== 16'h0000 || wave1 !== 16'h0000) begin
            errors++; $display("FAIL reset_wavelet: got %h/%h expected 0000/0000", wave0, wave1);
        end
    endtask

    task automatic test_filter_val();
        run_calc({8'd100, 8'd3, -8'sd77, 8'd45, -8'sd128, 8'd127, 8'd19}, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_full_scale();
        write_all(0, NE-1, 127);
        write_all(NE, NCOEF-1, -128);
        run_calc({NE{8'd127}}, 1'b0, 1'b0, 0, 0);
        checks++;
        if (wave0 !== {8'hC8, 8'h37} || wave1 !== {8'hC8, 8'h37}) begin
            errors++;
            $display("FAIL full_scale: got %h/%h expected c837/c837", wave0, wave1);
        end
    endtask

    task automatic test_round_and_write_start();
        write_all(0, NCOEF-1, 0);
        // coef(1,0)=32 written on the very cycle the start is accepted
        run_calc({{(NE-1){8'd0}}, 8'd32}, 1'b0, 1'b1, NE, 32);
        checks++;
        if (wave0 !== 16'h0000 || wave1 !== 16'h0100) begin
            errors++;
            $display("FAIL round_half: got %h/%h expected 0000/0100", wave0, wave1);
        end
    endtask

    task automatic test_busy_ignore();
        write_all(0, NE-1, 127);
        write_all(NE, NCOEF-1, -128);
        run_calc({NE{8'd127}}, 1'b1, 1'b0, 0, 0);
        no_valid_window(20, "second_valid");
        // A dropped write to coef 0 leaves the full-scale answer intact.
        run_calc({NE{8'd127}}, 1'b0, 1'b0, 0, 0);
        checks++;
        if (wave0 !== {8'hC8, 8'h37}) begin
            errors++;
            $display("FAIL dropped_write: got %h expected c837", wave0);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        taps = {NE{8'd90}}; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || valid0 !== 1'b0 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_status: busy %b/%b valid %b/%b expected 0", busy0, busy1, valid0, valid1);
        end
        checks++;
        if (wave0 !== 16'h0000 || wave1 !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_wavelet: got %h/%h expected 0000/0000", wave0, wave1);
        end
        no_valid_window(20, "midreset_valid");
        load_fv_model();
        run_calc({8'd7, -8'sd100, 8'd55, 8'd127, -8'sd1, 8'd64, -8'sd128}, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [NE*B-1:0] tp;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 3; k++) begin
                write_coef(int'($urandom_range(NCOEF-1, 0)), int'($urandom_range(255, 0)) - 128);
            end
            for (int e = 0; e < NE; e++) tp[e*B +: B] = 8'($urandom_range(255, 0));
            run_calc(tp, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_filter_val();
        test_full_scale();
        test_round_and_write_start();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fir_seq_multi.md
FIR_SEQ_MULTI -- requirements
Module: fir_seq_multi

Interface
REQ-001 SHALL have parameter BITS_PER_ELEM, default 8, signed width of each tap and coefficient.
REQ-002 SHALL have parameter NUM_ELEM, default 7, taps per channel.
REQ-003 SHALL have parameter NUM_CHAN, default 4, number of independent coefficient sets (wavelet scales) sharing one tap vector.
REQ-004 SHALL have parameter SUM_TRUNCATION, default 8, signed output width per channel.
REQ-005 SHALL have parameter ROUND, default 1; 0 = floor truncation, 1 = round-half-up with saturation.
REQ-006 SHALL have parameter FILTER_VAL, default 0, width NUM_CHAN*NUM_ELEM*BITS_PER_ELEM, holding the reset coefficients; element (c,e) is at index c*NUM_ELEM+e.
REQ-007 SHALL have port clk, input, 1, the single clock; all state SHALL be updated on its rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port i_start_calc, input, 1, request to start one computation.
REQ-010 SHALL have port taps, input, NUM_ELEM*BITS_PER_ELEM, signed samples; tap e is at bits [e*BITS_PER_ELEM +: BITS_PER_ELEM].
REQ-011 SHALL have port i_coef_we, input, 1, coefficient write strobe.
REQ-012 SHALL have port i_coef_addr, input, clog2(NUM_CHAN*NUM_ELEM), coefficient index c*NUM_ELEM+e.
REQ-013 SHALL have port i_coef_data, input, BITS_PER_ELEM, signed coefficient value.
REQ-014 SHALL have port o_busy, output, 1, high whenever the state is not IDLE.
REQ-015 SHALL have port o_valid, output, 1, one-cycle completion pulse.
REQ-016 SHALL have port o_wavelet, output, NUM_CHAN*SUM_TRUNCATION, per-channel signed results; channel c is at bits [c*SUM_TRUNCATION +: SUM_TRUNCATION].

Function
REQ-017 SHALL define ACC_BITS = 2*BITS_PER_ELEM + clog2(NUM_ELEM) and SHIFT = ACC_BITS - SUM_TRUNCATION; elaboration SHALL fail if SHIFT < 1.
REQ-018 SHALL implement the states IDLE, CALC and DONE with a single signed BITS_PER_ELEM x BITS_PER_ELEM multiplier.
REQ-019 IDLE: an i_start_calc sampled high SHALL snapshot taps into an internal register, clear the accumulator, set c=0 and e=0, and move to CALC.
REQ-020 CALC: each cycle SHALL add coef(c,e)*snapshot_tap(e), sign-extended to ACC_BITS, and then advance e; when e wraps from NUM_ELEM-1 it SHALL requantise the accumulator into staging slot c, clear the accumulator and advance c.
REQ-021 CALC SHALL move to DONE after the product for (NUM_CHAN-1, NUM_ELEM-1), loading all staging slots into o_wavelet together on that same edge.
REQ-022 DONE SHALL last exactly one cycle with o_valid=1 and SHALL then return to IDLE.
REQ-023 Latency: for a start sampled at edge k, o_valid SHALL be high in the cycle after edge k+NUM_CHAN*NUM_ELEM, and o_busy SHALL be high from edge k until o_valid falls.
REQ-024 Requantise with ROUND=0: the result SHALL be acc >>> SHIFT (arithmetic shift, floor).
REQ-025 Requantise with ROUND=1: the result SHALL be (acc + 2^(SHIFT-1)) >>> SHIFT, computed without overflow and clamped to [-2^(SUM_TRUNCATION-1), 2^(SUM_TRUNCATION-1)-1].
REQ-026 i_start_calc SHALL be ignored while o_busy is high; there is no queueing.
REQ-027 Changes on taps after the start is accepted SHALL NOT affect the result in progress.
REQ-028 A coefficient write SHALL commit only in IDLE; a write while o_busy is high SHALL be dropped.
REQ-029 A write and a start in the same IDLE cycle SHALL both be accepted, and the computation SHALL use the new coefficient.
REQ-030 o_wavelet SHALL hold its value between completions.

Reset
REQ-031 rst high SHALL, at the next edge, force the state to IDLE, clear the accumulator, staging slots and o_wavelet to 0, set o_valid=0 and o_busy=0, and reload coefficients from FILTER_VAL.
REQ-032 Reset asserted mid-CALC SHALL abort the computation with no o_valid pulse; rst SHALL take priority over start and write.

Structure
REQ-033 A shared package fir_pkg SHALL hold the state encoding constants and the ACC_BITS/SHIFT width function.
REQ-034 Requantisation SHALL be a combinational sub-module fir_requant, parameterised by ACC_BITS, SUM_TRUNCATION and ROUND.

Verification (BITS_PER_ELEM=8, NUM_ELEM=7, NUM_CHAN=2, SUM_TRUNCATION=8, so ACC_BITS=19 and SHIFT=11)
REQ-035 Set all ch0 coefficients to 127 and all taps to 127, start at edge k -> o_valid only in the cycle after edge k+14, ch0 result = 55 (acc 112903).
REQ-036 Set all ch1 coefficients to -128 and all taps to 127 -> ch1 result = -56 for both ROUND=0 and ROUND=1.
REQ-037 Set ch1 coef(1,0)=32, tap0=32, all other values 0 -> ch1 result = 1 with ROUND=1 and 0 with ROUND=0.
REQ-038 Change taps and assert i_start_calc and i_coef_we during CALC -> result unchanged from REQ-035, no second o_valid, and a subsequent coefficient readback shows the old value.
REQ-039 Assert rst at edge k+5 of a computation -> no o_valid, o_wavelet=0, o_busy=0 at edge k+6, and coefficients equal FILTER_VAL.
